// File: rtl/arb2_stream_sel_pkg.sv
// Shared types and constants for the two-input round-robin stream arbiter.
package arb2_pkg;

  localparam int unsigned DW_DEFAULT = 8;

  typedef logic sel_t;
  localparam sel_t SEL_W0 = 1'b0;
  localparam sel_t SEL_W1 = 1'b1;

  typedef enum logic [1:0] {
    LK_NONE,
    LK_W0,
    LK_W1
  } lock_t;

endpackage

// File: rtl/arb2_stream_sel_if.sv
// Source/sink stream bundle for arb2_stream_sel; last signals exist only with ARB2_PKT_LOCK_EN.
interface arb2_stream_sel_if #(
  parameter int unsigned DW = arb2_pkg::DW_DEFAULT
);

  logic [DW-1:0] w0_data;
  logic          w0_valid;
  logic          w0_ready;
  logic [DW-1:0] w1_data;
  logic          w1_valid;
  logic          w1_ready;
  logic [DW-1:0] f_data;
  logic          f_valid;
  logic          f_ready;
  logic          s;
`ifdef ARB2_PKT_LOCK_EN
  logic          w0_last;
  logic          w1_last;
  logic          f_last;

  modport master (
    input  w0_data, w0_valid, w0_last, w1_data, w1_valid, w1_last, f_ready,
    output w0_ready, w1_ready, f_data, f_valid, f_last, s
  );
  modport slave (
    output w0_data, w0_valid, w0_last, w1_data, w1_valid, w1_last, f_ready,
    input  w0_ready, w1_ready, f_data, f_valid, f_last, s
  );
`else
  modport master (
    input  w0_data, w0_valid, w1_data, w1_valid, f_ready,
    output w0_ready, w1_ready, f_data, f_valid, s
  );
  modport slave (
    output w0_data, w0_valid, w1_data, w1_valid, f_ready,
    input  w0_ready, w1_ready, f_data, f_valid, s
  );
`endif

endinterface

// File: rtl/arb2_stream_sel_rr2_grant.sv
// Combinational two-way round-robin grant with optional lock override and next-last_grant.
module rr2_grant
  import arb2_pkg::*;
(
  input  logic i_w0_valid,
  input  logic i_w1_valid,
  input  sel_t i_last_grant,
  input  logic i_locked,
  input  sel_t i_lock_sel,
  input  logic i_update,
  output sel_t o_grant,
  output logic o_any,
  output sel_t o_next_last_grant
);

  always_comb begin
    o_grant = SEL_W0;
    o_any   = 1'b0;
    if (i_locked) begin
      // A locked source keeps the grant even while idle; the other source is never served.
      o_grant = i_lock_sel;
      o_any   = (i_lock_sel == SEL_W1) ? i_w1_valid : i_w0_valid;
    end else if (i_w0_valid && i_w1_valid) begin
      o_grant = (i_last_grant == SEL_W1) ? SEL_W0 : SEL_W1;
      o_any   = 1'b1;
    end else if (i_w0_valid) begin
      o_grant = SEL_W0;
      o_any   = 1'b1;
    end else if (i_w1_valid) begin
      o_grant = SEL_W1;
      o_any   = 1'b1;
    end
    o_next_last_grant = (i_update && o_any) ? o_grant : i_last_grant;
  end

endmodule

// File: rtl/arb2_stream_sel.sv
// Two-input round-robin stream arbiter with one registered output stage.
// Define ARB2_PKT_LOCK_EN to hold the grant for a whole packet (w*_last / f_last).
module arb2_stream_sel
  import arb2_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  arb2_stream_sel_if.master bus
);

  logic          w_load;
  logic          w_any;
  logic          w_xfer;
  logic          w_locked;
  logic          w_update;
  sel_t          w_grant;
  sel_t          w_lock_sel;
  sel_t          w_next_last;
  logic [DW-1:0] w_data;

  sel_t          r_last_grant;
  sel_t          r_s;
  logic [DW-1:0] r_f_data;
  logic          r_f_valid;

  assign w_load = !r_f_valid || bus.f_ready;
  assign w_xfer = w_load && w_any;
  assign w_data = (w_grant == SEL_W1) ? bus.w1_data : bus.w0_data;

  rr2_grant u_grant (
    .i_w0_valid        (bus.w0_valid),
    .i_w1_valid        (bus.w1_valid),
    .i_last_grant      (r_last_grant),
    .i_locked          (w_locked),
    .i_lock_sel        (w_lock_sel),
    .i_update          (w_update),
    .o_grant           (w_grant),
    .o_any             (w_any),
    .o_next_last_grant (w_next_last)
  );

`ifdef ARB2_PKT_LOCK_EN
  lock_t r_lock;
  lock_t w_lock_nxt;
  logic  w_beat_last;
  logic  r_f_last;

  assign w_beat_last = (w_grant == SEL_W1) ? bus.w1_last : bus.w0_last;
  assign w_locked    = (r_lock != LK_NONE);
  assign w_lock_sel  = (r_lock == LK_W1) ? SEL_W1 : SEL_W0;
  // Round-robin pointer only advances when a packet ends, not on every beat.
  assign w_update    = w_load && w_beat_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lock <= LK_NONE;
    else        r_lock <= w_lock_nxt;
  end

  always_comb begin
    w_lock_nxt = r_lock;
    if (w_xfer) begin
      if (w_beat_last)             w_lock_nxt = LK_NONE;
      else if (w_grant == SEL_W1)  w_lock_nxt = LK_W1;
      else                         w_lock_nxt = LK_W0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_f_last <= 1'b0;
    else if (w_xfer) r_f_last <= w_beat_last;
  end

  assign bus.f_last = r_f_last;
`else
  assign w_locked   = 1'b0;
  assign w_lock_sel = SEL_W0;
  assign w_update   = w_load;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_data     <= '0;
      r_f_valid    <= 1'b0;
      r_s          <= SEL_W0;
      r_last_grant <= SEL_W1;
    end else begin
      if (w_xfer) begin
        r_f_data  <= w_data;
        r_f_valid <= 1'b1;
        r_s       <= w_grant;
      end else if (w_load) begin
        r_f_valid <= 1'b0;
      end
      r_last_grant <= w_next_last;
    end
  end

  assign bus.w0_ready = w_xfer && (w_grant == SEL_W0);
  assign bus.w1_ready = w_xfer && (w_grant == SEL_W1);
  assign bus.f_data   = r_f_data;
  assign bus.f_valid  = r_f_valid;
  assign bus.s        = r_s;

endmodule

// File: tb/tb_arb2_stream_sel.sv
// Bench for arb2_stream_sel: directed scenarios plus random traffic against a behavioural model.
module tb_arb2_stream_sel;
  import arb2_pkg::*;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arb2_stream_sel_if #(.DW(DW)) bus ();

  arb2_stream_sel #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state: output register contents, round-robin pointer, packet lock (-1 = none).
  bit         m_fv;
  logic [7:0] m_fd;
  bit         m_s;
  bit         m_flast;
  bit         m_last;
  int         m_lock;
  bit         m_r0;
  bit         m_r1;
  logic [7:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_fv    = 1'b0;
    m_fd    = 8'h00;
    m_s     = 1'b0;
    m_flast = 1'b0;
    m_last  = 1'b1;
    m_lock  = -1;
    m_r0    = 1'b0;
    m_r1    = 1'b0;
    sb.delete();
  endfunction

  function automatic void model_grant(output bit any, output bit g);
    bit v0 = bus.w0_valid;
    bit v1 = bus.w1_valid;
    any = 1'b0;
    g   = 1'b0;
    if (m_lock >= 0) begin
      g   = (m_lock == 1);
      any = g ? v1 : v0;
    end else if (v0 && v1) begin
      g   = !m_last;
      any = 1'b1;
    end else if (v0 || v1) begin
      g   = v1;
      any = 1'b1;
    end
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit load, any, g, lst;
    @(negedge clk);
    load = !m_fv || bus.f_ready;
    model_grant(any, g);
    m_r0 = load && any && !g;
    m_r1 = load && any && g;
    check_eq("w0_ready", bus.w0_ready, m_r0);
    check_eq("w1_ready", bus.w1_ready, m_r1);
    check_eq("f_valid", bus.f_valid, m_fv);
    check_eq("f_data", bus.f_data, m_fd);
    check_eq("s", bus.s, m_s);
`ifdef ARB2_PKT_LOCK_EN
    check_eq("f_last", bus.f_last, m_flast);
`endif
    if (m_fv && bus.f_ready && sb.size() > 0)
      check_eq("sb_word", bus.f_data, sb.pop_front());
    @(posedge clk);
    if (load && any) begin
      m_fd = g ? bus.w1_data : bus.w0_data;
      m_fv = 1'b1;
      m_s  = g;
      sb.push_back(m_fd);
`ifdef ARB2_PKT_LOCK_EN
      lst     = g ? bus.w1_last : bus.w0_last;
      m_flast = lst;
      if (lst) begin
        m_lock = -1;
        m_last = g;
      end else begin
        m_lock = g ? 1 : 0;
      end
`else
      lst    = 1'b1;
      m_last = g;
`endif
    end else if (load) begin
      m_fv = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.w0_valid = 1'b0;
    bus.w1_valid = 1'b0;
    bus.w0_data  = '0;
    bus.w1_data  = '0;
    bus.f_ready  = 1'b0;
`ifdef ARB2_PKT_LOCK_EN
    bus.w0_last  = 1'b1;
    bus.w1_last  = 1'b1;
`endif
  endtask

  logic [7:0] alt_data[4] = '{8'h11, 8'h22, 8'h11, 8'h22};

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #22 rst_n = 1'b1;

    // Reset state visible on the first sampled cycle.
    cycle();

    // Alternation under contention.
    bus.w0_data  = 8'h11;
    bus.w1_data  = 8'h22;
    bus.w0_valid = 1'b1;
    bus.w1_valid = 1'b1;
    bus.f_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("alt_data", bus.f_data, alt_data[k]);
      check_eq("alt_s", bus.s, k % 2);
    end
    bus.w0_valid = 1'b0;
    bus.w1_valid = 1'b0;

    // Single source.
    bus.w1_valid = 1'b1;
    bus.w1_data  = 8'h5A;
    cycle();
    check_eq("single_data", bus.f_data, 8'h5A);
    check_eq("single_s", bus.s, 1'b1);
    check_eq("single_valid", bus.f_valid, 1'b1);
    bus.w1_valid = 1'b0;

    // Backpressure with a held 0xA5 word.
    bus.w0_valid = 1'b1;
    bus.w0_data  = 8'hA5;
    cycle();
    bus.f_ready  = 1'b0;
    bus.w0_data  = 8'h11;
    bus.w1_valid = 1'b1;
    bus.w1_data  = 8'h22;
    repeat (3) begin
      cycle();
      check_eq("bp_hold", bus.f_data, 8'hA5);
    end
    bus.f_ready = 1'b1;
    cycle();
    check_eq("bp_release", bus.f_data, 8'h22);
    bus.w0_valid = 1'b0;
    bus.w1_valid = 1'b0;

    // Drain: valid drops, select holds.
    cycle();
    check_eq("drain_valid", bus.f_valid, 1'b0);
    check_eq("drain_s", bus.s, 1'b1);

`ifdef ARB2_PKT_LOCK_EN
    // Three-beat w0 packet while w1 stays valid.
    bus.w1_valid = 1'b1;
    bus.w1_data  = 8'h77;
    bus.w1_last  = 1'b1;
    bus.w0_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bus.w0_data = 8'hB0 + 8'(b);
      bus.w0_last = (b == 2);
      cycle();
      check_eq("pkt_data", bus.f_data, 8'hB0 + 8'(b));
      check_eq("pkt_last", bus.f_last, (b == 2));
    end
    bus.w0_data = 8'hC0;
    bus.w0_last = 1'b1;
    cycle();
    check_eq("pkt_next_w1", bus.f_data, 8'h77);
    bus.w0_valid = 1'b0;
    bus.w1_valid = 1'b0;
    cycle();
`endif

    // Random traffic respecting the hold-until-ready rule.
    for (int n = 0; n < 2000; n++) begin
      bus.f_ready = ($urandom_range(0, 3) != 0);
      if (bus.w0_valid ? m_r0 : 1'b1) begin
        bus.w0_valid = ($urandom_range(0, 2) != 0);
        bus.w0_data  = 8'($urandom);
`ifdef ARB2_PKT_LOCK_EN
        bus.w0_last  = ($urandom_range(0, 2) == 0);
`endif
      end
      if (bus.w1_valid ? m_r1 : 1'b1) begin
        bus.w1_valid = ($urandom_range(0, 2) != 0);
        bus.w1_data  = 8'($urandom);
`ifdef ARB2_PKT_LOCK_EN
        bus.w1_last  = ($urandom_range(0, 2) == 0);
`endif
      end
      cycle();
    end

    // Asynchronous reset while a word sits in the output register.
    idle_inputs();
    cycle();
    cycle();
    bus.w0_valid = 1'b1;
    bus.w0_data  = 8'hC3;
    bus.f_ready  = 1'b1;
    cycle();
    bus.w0_valid = 1'b0;
    bus.f_ready  = 1'b0;
    check_eq("pre_rst_valid", bus.f_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_valid", bus.f_valid, 1'b0);
    check_eq("rst_data", bus.f_data, 8'h00);
    check_eq("rst_s", bus.s, 1'b0);
`ifdef ARB2_PKT_LOCK_EN
    check_eq("rst_last", bus.f_last, 1'b0);
`endif
    model_reset();
    idle_inputs();
    #10 rst_n = 1'b1;

    // First contention after reset goes to w0.
    bus.w0_valid = 1'b1;
    bus.w0_data  = 8'h3C;
    bus.w1_valid = 1'b1;
    bus.w1_data  = 8'h4D;
    bus.f_ready  = 1'b1;
    cycle();
    check_eq("post_rst_s", bus.s, 1'b0);
    check_eq("post_rst_data", bus.f_data, 8'h3C);
    bus.w0_valid = 1'b0;
    bus.w1_valid = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
